sys_bus_arbiter: RTL

//  Shares one sys_bus master port (the interconnect input) between NM requesters, e.g. the AXI bridge and an on-chip sequencer.

---
 rtl/sys_bus_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing one sys_bus master port between NM requesters.
// Strobes are latched per requester and replayed on the bus one access at a time.
module sys_bus_arbiter #(
  parameter int NM  = 2,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NM*AW-1:0] m_addr_i,
  input  logic [NM*DW-1:0] m_wdata_i,
  input  logic [NM-1:0]    m_wen_i,
  input  logic [NM-1:0]    m_ren_i,
  output logic [NM*DW-1:0] m_rdata_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [AW-1:0]    s_addr_o,
  output logic [DW-1:0]    s_wdata_o,
  output logic             s_wen_o,
  output logic             s_ren_o,
  input  logic [DW-1:0]    s_rdata_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  output logic [NM-1:0]    grant_o,
  output logic [NM-1:0]    ovr_o
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [CW-1:0] TMO_C   = CW'(TMO);
  localparam logic [IW-1:0] PTR_RST = IW'(NM - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  logic [NM-1:0] r_pend;
  logic [NM-1:0] r_op;
  logic [NM-1:0] r_ovr;
  logic [NM-1:0] r_grant;
  logic [NM-1:0] r_m_ack;
  logic [NM-1:0] r_m_err;
  logic [AW-1:0] r_addr    [NM];
  logic [DW-1:0] r_wdata   [NM];
  logic [DW-1:0] r_m_rdata [NM];
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_gidx;
  logic [CW-1:0] r_cnt;
  logic          r_is_wr;
  logic [AW-1:0] r_s_addr;
  logic [DW-1:0] r_s_wdata;
  logic          r_s_wen;
  logic          r_s_ren;

  logic [NM-1:0] w_stb;
  logic [NM-1:0] w_clr;
  logic [AW-1:0] w_addr  [NM];
  logic [DW-1:0] w_wdata [NM];
  logic [IW-1:0] w_win;
  logic          w_any;

  generate
    for (genvar gi = 0; gi < NM; gi++) begin : g_slice
      assign w_addr[gi]                = m_addr_i[gi*AW +: AW];
      assign w_wdata[gi]               = m_wdata_i[gi*DW +: DW];
      assign m_rdata_o[gi*DW +: DW]    = r_m_rdata[gi];
    end
  endgenerate

  assign w_stb = m_wen_i | m_ren_i;
  // The owner's pend flag clears during DONE, so a fresh strobe that cycle is accepted.
  assign w_clr = (r_state == S_DONE) ? r_grant : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend <= '0;
      r_op   <= '0;
      r_ovr  <= '0;
      for (int i = 0; i < NM; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
      end
    end else begin
      r_ovr <= w_stb & r_pend & ~w_clr;
      for (int i = 0; i < NM; i++) begin
        if (w_stb[i] && (!r_pend[i] || w_clr[i])) begin
          r_pend[i]  <= 1'b1;
          r_op[i]    <= m_wen_i[i];
          r_addr[i]  <= w_addr[i];
          r_wdata[i] <= w_wdata[i];
        end else if (w_clr[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // First pending index above the pointer wins; otherwise wrap to the lowest one.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (!w_any && r_pend[i] && (i > int'(r_ptr))) begin
        w_any = 1'b1;
        w_win = IW'(i);
      end
    end
    for (int i = 0; i < NM; i++) begin
      if (!w_any && r_pend[i] && (i <= int'(r_ptr))) begin
        w_any = 1'b1;
        w_win = IW'(i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_ptr     <= PTR_RST;
      r_gidx    <= '0;
      r_grant   <= '0;
      r_cnt     <= '0;
      r_is_wr   <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_wen   <= 1'b0;
      r_s_ren   <= 1'b0;
      r_m_ack   <= '0;
      r_m_err   <= '0;
      for (int i = 0; i < NM; i++) r_m_rdata[i] <= '0;
    end else begin
      r_s_wen <= 1'b0;
      r_s_ren <= 1'b0;
      r_m_ack <= '0;
      r_m_err <= '0;
      for (int i = 0; i < NM; i++) r_m_rdata[i] <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant   <= NM'(1) << w_win;
            r_gidx    <= w_win;
            r_is_wr   <= r_op[w_win];
            r_s_wen   <= r_op[w_win];
            r_s_ren   <= ~r_op[w_win];
            r_s_addr  <= r_addr[w_win];
            r_s_wdata <= r_wdata[w_win];
            r_cnt     <= '0;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (s_ack_i || s_err_i) begin
            r_m_ack[r_gidx]   <= 1'b1;
            r_m_err[r_gidx]   <= s_err_i;
            r_m_rdata[r_gidx] <= r_is_wr ? '0 : s_rdata_i;
            r_s_addr          <= '0;
            r_s_wdata         <= '0;
            r_state           <= S_DONE;
          end else if ((TMO > 0) && (r_cnt == TMO_C)) begin
            r_m_ack[r_gidx] <= 1'b1;
            r_m_err[r_gidx] <= 1'b1;
            r_s_addr        <= '0;
            r_s_wdata       <= '0;
            r_state         <= S_DONE;
          end else begin
            if (TMO > 0) r_cnt <= r_cnt + CW'(1);
            r_state <= S_WAIT;
          end
        end
        S_DONE: begin
          r_ptr   <= r_gidx;
          r_grant <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_ack_o   = r_m_ack;
  assign m_err_o   = r_m_err;
  assign s_addr_o  = r_s_addr;
  assign s_wdata_o = r_s_wdata;
  assign s_wen_o   = r_s_wen;
  assign s_ren_o   = r_s_ren;
  assign grant_o   = r_grant;
  assign ovr_o     = r_ovr;

endmodule
